// File: rtl/vga_fb_reader.sv
// Frame-buffer reader: walks one H_VISIBLE x V_VISIBLE frame over an AXI-lite
// read channel and streams the returned words out as tagged pixels.
// Read issue is limited by credits, so the output FIFO can never overflow.
module vga_fb_reader #(
    parameter int unsigned AXI_ADDR_WIDTH = 20,
    parameter int unsigned AXI_DATA_WIDTH = 16,
    parameter int unsigned H_VISIBLE      = 640,
    parameter int unsigned V_VISIBLE      = 480,
    parameter int unsigned FIFO_DEPTH     = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      frame_start,
    input  logic                      buf_sel,
    output logic                      busy,
    output logic [AXI_ADDR_WIDTH-1:0] axi_araddr,
    output logic                      axi_arvalid,
    input  logic                      axi_arready,
    input  logic [AXI_DATA_WIDTH-1:0] axi_rdata,
    input  logic [1:0]                axi_rresp,
    input  logic                      axi_rvalid,
    output logic                      axi_rready,
    output logic [AXI_DATA_WIDTH-1:0] pix_data,
    output logic                      pix_valid,
    input  logic                      pix_ready,
    output logic                      pix_last_x,
    output logic                      pix_last_frame,
    output logic                      rd_err
);

    localparam int unsigned OW   = AXI_ADDR_WIDTH - 1;
    localparam int unsigned XW   = (H_VISIBLE > 1) ? $clog2(H_VISIBLE) : 1;
    localparam int unsigned YW   = (V_VISIBLE > 1) ? $clog2(V_VISIBLE) : 1;
    localparam int unsigned PW   = $clog2(FIFO_DEPTH);
    localparam int unsigned CNTW = PW + 1;
    localparam int unsigned CW   = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned EW   = AXI_DATA_WIDTH + 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t            state_q,   state_d;
    logic              bufsel_q,  bufsel_d;
    logic              arvalid_q, arvalid_d;
    logic [OW-1:0]     offset_q,  offset_d;
    logic [XW-1:0]     x_q,       x_d;
    logic [YW-1:0]     y_q,       y_d;
    logic [CW-1:0]     credits_q, credits_d;
    logic [XW-1:0]     rx_q,      rx_d;
    logic [YW-1:0]     ry_q,      ry_d;
    logic [PW-1:0]     wr_ptr_q,  wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q,  rd_ptr_d;
    logic [CNTW-1:0]   count_q,   count_d;
    logic              rd_err_q,  rd_err_d;
    logic [EW-1:0]     mem_q [FIFO_DEPTH];

    logic              ar_hs;
    logic              push;
    logic              pop;
    logic              ar_final;
    logic              rx_last;
    logic              ry_last;
    logic [EW-1:0]     wdata;
    logic [EW-1:0]     head;

    // Handshake and position decodes shared by the next-state logic
    assign ar_hs    = arvalid_q & axi_arready;
    assign push     = axi_rvalid;
    assign pop      = (count_q != '0) & pix_ready;
    assign ar_final = (x_q == XW'(H_VISIBLE - 1)) && (y_q == YW'(V_VISIBLE - 1));
    assign rx_last  = (rx_q == XW'(H_VISIBLE - 1));
    assign ry_last  = (ry_q == YW'(V_VISIBLE - 1));
    assign wdata    = {rx_last & ry_last, rx_last, axi_rdata};
    assign head     = mem_q[rd_ptr_q];

    // Next-state: frame control, address walk, credits, FIFO pointers, return tags
    always_comb begin
        state_d   = state_q;
        bufsel_d  = bufsel_q;
        arvalid_d = arvalid_q;
        offset_d  = offset_q;
        x_d       = x_q;
        y_d       = y_q;
        rx_d      = rx_q;
        ry_d      = ry_q;
        rd_err_d  = rd_err_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        credits_d = credits_q - CW'(ar_hs) + CW'(pop);
        count_d   = count_q + CNTW'(push) - CNTW'(pop);

        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
            if (rx_last) begin
                rx_d = '0;
                ry_d = ry_q + YW'(1);
            end else begin
                rx_d = rx_q + XW'(1);
            end
            if (axi_rresp != 2'b00) begin
                rd_err_d = 1'b1;
            end
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (frame_start) begin
                    state_d   = ST_READ;
                    bufsel_d  = buf_sel;
                    rd_err_d  = 1'b0;
                    offset_d  = '0;
                    x_d       = '0;
                    y_d       = '0;
                    rx_d      = '0;
                    ry_d      = '0;
                    arvalid_d = (credits_d != '0);
                end
            end
            ST_READ: begin
                if (ar_hs) begin
                    if (ar_final) begin
                        arvalid_d = 1'b0;
                        state_d   = ST_DRAIN;
                    end else begin
                        offset_d  = offset_q + OW'(1);
                        if (x_q == XW'(H_VISIBLE - 1)) begin
                            x_d = '0;
                            y_d = y_q + YW'(1);
                        end else begin
                            x_d = x_q + XW'(1);
                        end
                        arvalid_d = (credits_d != '0);
                    end
                end else if (!arvalid_q) begin
                    arvalid_d = (credits_d != '0);
                end
            end
            ST_DRAIN: begin
                if (pop && head[EW-1]) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                arvalid_d = 1'b0;
            end
        endcase
    end

    // State and control registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            bufsel_q  <= 1'b0;
            arvalid_q <= 1'b0;
            offset_q  <= '0;
            x_q       <= '0;
            y_q       <= '0;
            credits_q <= CW'(FIFO_DEPTH);
            rx_q      <= '0;
            ry_q      <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            rd_err_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            bufsel_q  <= bufsel_d;
            arvalid_q <= arvalid_d;
            offset_q  <= offset_d;
            x_q       <= x_d;
            y_q       <= y_d;
            credits_q <= credits_d;
            rx_q      <= rx_d;
            ry_q      <= ry_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            rd_err_q  <= rd_err_d;
        end
    end

    // FIFO storage; contents are don't-care while the count says empty
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    assign busy           = (state_q != ST_IDLE);
    assign axi_araddr     = {bufsel_q, offset_q};
    assign axi_arvalid    = arvalid_q;
    assign axi_rready     = 1'b1;
    assign pix_valid      = (count_q != '0);
    assign pix_data       = head[AXI_DATA_WIDTH-1:0];
    assign pix_last_x     = head[EW-2];
    assign pix_last_frame = head[EW-1];
    assign rd_err         = rd_err_q;

endmodule
